// File: rtl/instr_fetch_unit.sv
// Program counter, ROM address generator, instruction and immediate registers.
// Optional retired-fetch counter is built only when FETCH_ICOUNT_EN is defined.
module instr_fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [1:0]        fetch,
    input  logic              PC_en,
    input  logic              pc_in,
    input  logic              im_int,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        ins,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] imm,
    output logic              halted,
    output logic [15:0]       icount
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              running;
    logic              ir_cap;
    logic              imm_cap;
    logic              hlt_seen;
    logic [ADDR_W-1:0] pc_next;

    assign rom_addr = pc;
    assign ins      = ir[DATA_W-1 -: 4];

    // Decode which registers update this cycle; all events read the old pc.
    always_comb begin
        running  = (state == RUN);
        ir_cap   = running && (fetch == 2'b01) && !pc_in;
        imm_cap  = running && im_int;
        hlt_seen = ir_cap && (rom_data[DATA_W-1 -: 4] == OP_HLT);
        pc_next  = pc;
        if (running && PC_en) begin
            if (pc_in) begin
                pc_next = ADDR_W'(rom_data);
            end else begin
                pc_next = pc + ADDR_W'(1);
            end
        end
    end

    // Run/halt controller; halted is a registered copy of the halt state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hlt_seen) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: increment, jump or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Instruction register captures opcode bytes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_cap) begin
            ir <= rom_data;
        end
    end

    // Immediate register captures operand bytes independently of fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm <= '0;
        end else if (imm_cap) begin
            imm <= rom_data;
        end
    end

`ifdef FETCH_ICOUNT_EN
    // Saturating count of opcode captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icount <= '0;
        end else if (ir_cap && (icount != 16'hFFFF)) begin
            icount <= icount + 16'd1;
        end
    end
`else
    assign icount = 16'h0000;
`endif

endmodule
